// File: rtl/prox_sensor_pkg.sv
// Shared types and constants for the proximity sensor front-end.
package prox_sensor_pkg;

    localparam int unsigned ACQ_DATA_WIDTH = 32;
    localparam int unsigned ACQ_AVG_LOG2_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        START,
        CONVERT,
        PUBLISH
    } acq_state_t;

    // Limit a requested averaging exponent to the supported maximum.
    function automatic logic [ACQ_AVG_LOG2_W-1:0] clamp_avg_log2(
        input logic [ACQ_AVG_LOG2_W-1:0] value,
        input logic [ACQ_AVG_LOG2_W-1:0] max_value
    );
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/sample_period_timer.sv
// Free-running burst timer: pulses tick_c once every max(period,1) cycles while enabled.
module sample_period_timer #(
    parameter int unsigned TIMER_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [TIMER_WIDTH-1:0] period,
    output logic                   tick_c
);

    logic [TIMER_WIDTH-1:0] count;
    logic [TIMER_WIDTH-1:0] last;

    // A period of 0 behaves as 1; >= keeps wrap safe if period shrinks below count.
    assign last   = (period == '0) ? '0 : period - TIMER_WIDTH'(1);
    assign tick_c = enable && !clear && (count >= last);

    // Count up, wrap on the terminal count, hold at zero when disabled or cleared.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!enable || clear) begin
            count <= '0;
        end else if (count >= last) begin
            count <= '0;
        end else begin
            count <= count + TIMER_WIDTH'(1);
        end
    end

endmodule

// File: rtl/sample_acquisition_ctrl.sv
// Periodic ADC burst sequencer: averages 2^n conversions and publishes one sample per burst.
module sample_acquisition_ctrl
    import prox_sensor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = ACQ_DATA_WIDTH,
    parameter int unsigned ADC_WIDTH      = 12,
    parameter int unsigned AVG_LOG2_MAX   = 3,
    parameter int unsigned TIMER_WIDTH    = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [TIMER_WIDTH-1:0]    sample_period,
    input  logic [ACQ_AVG_LOG2_W-1:0] avg_log2,
    input  logic                      err_clear,
    output logic                      adc_start,
    input  logic                      adc_done,
    input  logic [ADC_WIDTH-1:0]      adc_data,
    output logic                      data_valid,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int unsigned ACC_W = ADC_WIDTH + AVG_LOG2_MAX;
    localparam int unsigned CNT_W = AVG_LOG2_MAX + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    acq_state_t                state;
    logic [ACQ_AVG_LOG2_W-1:0] n_lat;
    logic [ACC_W-1:0]          acc;
    logic [CNT_W-1:0]          cnt;
    logic [TMO_W-1:0]          tmo;

    logic                      acq_tick;
    logic                      timer_clear;
    logic [ACC_W-1:0]          acc_next;
    logic [CNT_W-1:0]          cnt_next;
    logic [CNT_W-1:0]          cnt_target;
    logic [ACQ_AVG_LOG2_W-1:0] n_clamped;

    // Timer restarts from zero each time acquisition is (re)enabled.
    assign timer_clear = (state == IDLE);

    sample_period_timer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .clear (timer_clear),
        .period(sample_period),
        .tick_c(acq_tick)
    );

    // Datapath helpers for the accumulate/compare step in CONVERT.
    assign acc_next   = acc + ACC_W'(adc_data);
    assign cnt_next   = cnt + CNT_W'(1);
    assign cnt_target = CNT_W'(1) << n_lat;
    assign n_clamped  = clamp_avg_log2(avg_log2, ACQ_AVG_LOG2_W'(AVG_LOG2_MAX));

    // Burst FSM with registered strobes; a timeout set overrides a same-cycle err_clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            n_lat       <= '0;
            acc         <= '0;
            cnt         <= '0;
            tmo         <= '0;
            adc_start   <= 1'b0;
            data_valid  <= 1'b0;
            data_out    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            adc_start  <= 1'b0;
            data_valid <= 1'b0;
            if (err_clear) begin
                timeout_err <= 1'b0;
            end
            if (!enable) begin
                state <= IDLE;
                busy  <= 1'b0;
                acc   <= '0;
                cnt   <= '0;
                tmo   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= WAIT_TICK;
                    end
                    WAIT_TICK: begin
                        if (acq_tick) begin
                            state     <= START;
                            n_lat     <= n_clamped;
                            acc       <= '0;
                            cnt       <= '0;
                            adc_start <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                    START: begin
                        state <= CONVERT;
                        tmo   <= '0;
                    end
                    CONVERT: begin
                        if (adc_done) begin
                            acc <= acc_next;
                            cnt <= cnt_next;
                            if (cnt_next == cnt_target) begin
                                state      <= PUBLISH;
                                data_out   <= DATA_WIDTH'(acc_next >> n_lat);
                                data_valid <= 1'b1;
                            end else begin
                                state     <= START;
                                adc_start <= 1'b1;
                            end
                        end else if (tmo == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            timeout_err <= 1'b1;
                            acc         <= '0;
                            cnt         <= '0;
                            state       <= WAIT_TICK;
                            busy        <= 1'b0;
                        end else begin
                            tmo <= tmo + TMO_W'(1);
                        end
                    end
                    PUBLISH: begin
                        state <= WAIT_TICK;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sample_acquisition_ctrl.sv
// Self-checking bench for sample_acquisition_ctrl: table vectors, corner sequences, random bursts.
module tb_sample_acquisition_ctrl;

    localparam int TMO = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] sample_period = 16'd4;
    logic [2:0]  avg_log2 = 3'd0;
    logic        err_clear = 1'b0;
    logic        adc_start;
    logic        adc_done = 1'b0;
    logic [11:0] adc_data = 12'd0;
    logic        data_valid;
    logic [31:0] data_out;
    logic        busy;
    logic        timeout_err;

    always #5 clock = ~clock;

    sample_acquisition_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .sample_period(sample_period),
        .avg_log2     (avg_log2),
        .err_clear    (err_clear),
        .adc_start    (adc_start),
        .adc_done     (adc_done),
        .adc_data     (adc_data),
        .data_valid   (data_valid),
        .data_out     (data_out),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_base = 0;
    int P = 1;
    logic [11:0] smp [8];
    logic [11:0] junk = 12'hABC;
    bit hold_done = 1'b0;
    bit stray = 1'b0;
    bit rnd_cfg = 1'b0;

    typedef struct packed {
        int              period;
        int              avg;
        int              dly;
        logic [7:0][11:0] s;
        logic [31:0]     exp_out;
    } vec_t;

    vec_t vecs [6];

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    function automatic int rel();
        return cyc - en_base;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int clamp_lg(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Bursts start on edges that are multiples of the period counted from enable.
    function automatic int next_start(input int min_rel);
        int j;
        j = (min_rel < 1) ? 1 : min_rel;
        return ((j + P - 1) / P) * P;
    endfunction

    task automatic configure(input int period, input int avg);
        sample_period = 16'(period);
        avg_log2      = 3'(avg);
        P             = (period == 0) ? 1 : period;
    endtask

    task automatic enable_on();
        enable = 1'b1;
        step();
        en_base = cyc;
    endtask

    task automatic disable_acq();
        enable = 1'b0;
        step();
        step();
    endtask

    task automatic wait_start(input int exp_rel);
        while (rel() < exp_rel) begin
            step();
            if (rel() < exp_rel) begin
                chk("no_early_start", adc_start, 1'b0);
            end else begin
                chk("start_on_tick", adc_start, 1'b1);
                chk("busy_in_burst", busy, 1'b1);
            end
        end
    endtask

    // Run one burst of 2^lg conversions, each answered dly cycles after adc_start.
    task automatic burst(input int exp_rel, input int lg, input int dly, output int pub_rel);
        int n;
        logic [31:0] sum;
        n   = 1 << lg;
        sum = 32'd0;
        wait_start(exp_rel);
        if (rnd_cfg) avg_log2 = 3'($urandom_range(0, 7));
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < dly; i++) begin
                adc_done = hold_done || (stray && i == 0);
                adc_data = junk;
                step();
                chk("no_start_while_converting", adc_start, 1'b0);
                chk("no_early_valid", data_valid, 1'b0);
            end
            adc_done = 1'b1;
            adc_data = smp[k];
            step();
            sum      = sum + 32'(smp[k]);
            adc_done = hold_done;
            adc_data = junk;
            if (k < n - 1) begin
                chk("restart_after_done", adc_start, 1'b1);
                chk("no_valid_mid_burst", data_valid, 1'b0);
            end else begin
                chk("valid_after_last_done", data_valid, 1'b1);
                chk("average", data_out, sum >> lg);
                chk("busy_in_publish", busy, 1'b1);
            end
        end
        pub_rel = rel();
        step();
        chk("valid_one_cycle", data_valid, 1'b0);
        chk("busy_low_after_publish", busy, 1'b0);
        chk("data_held", data_out, sum >> lg);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pr;
        int t;
        logic [31:0] old;

        vecs[0].period = 4; vecs[0].avg = 0; vecs[0].dly = 3; vecs[0].exp_out = 32'h123;
        vecs[0].s = {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'h123};
        vecs[1].period = 5; vecs[1].avg = 2; vecs[1].dly = 2; vecs[1].exp_out = 32'd25;
        vecs[1].s = {12'd0, 12'd0, 12'd0, 12'd0, 12'd41, 12'd30, 12'd20, 12'd10};
        vecs[2].period = 3; vecs[2].avg = 3; vecs[2].dly = 1; vecs[2].exp_out = 32'hFFF;
        vecs[2].s = {8{12'hFFF}};
        vecs[3].period = 2; vecs[3].avg = 7; vecs[3].dly = 2; vecs[3].exp_out = 32'hFFF;
        vecs[3].s = {8{12'hFFF}};
        vecs[4].period = 6; vecs[4].avg = 1; vecs[4].dly = 4; vecs[4].exp_out = 32'd7;
        vecs[4].s = {12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd8, 12'd7};
        vecs[5].period = 1; vecs[5].avg = 3; vecs[5].dly = 1; vecs[5].exp_out = 32'd4;
        vecs[5].s = {12'd8, 12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1};

        // Reset state
        step();
        step();
        chk("reset_adc_start", adc_start, 1'b0);
        chk("reset_data_valid", data_valid, 1'b0);
        chk("reset_data_out", data_out, 32'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_timeout_err", timeout_err, 1'b0);
        reset = 1'b0;
        step();

        // Table vectors: two bursts each
        for (int i = 0; i < 6; i++) begin
            disable_acq();
            configure(vecs[i].period, vecs[i].avg);
            for (int k = 0; k < 8; k++) smp[k] = vecs[i].s[k];
            enable_on();
            burst(next_start(1), clamp_lg(vecs[i].avg), vecs[i].dly, pr);
            chk("table_out_first", data_out, vecs[i].exp_out);
            burst(next_start(pr + 2), clamp_lg(vecs[i].avg), vecs[i].dly, pr);
            chk("table_out_second", data_out, vecs[i].exp_out);
        end

        // ADC never answers: timeout, restart, sticky flag, clear
        disable_acq();
        configure(3, 0);
        enable_on();
        wait_start(next_start(1));
        adc_done = 1'b0;
        for (int k = 1; k <= TMO + 1; k++) begin
            step();
            chk("no_valid_on_timeout", data_valid, 1'b0);
            if (k == TMO) begin
                chk("no_timeout_early", timeout_err, 1'b0);
                chk("busy_while_waiting", busy, 1'b1);
            end
        end
        chk("timeout_set", timeout_err, 1'b1);
        chk("busy_after_timeout", busy, 1'b0);
        t = rel();
        smp[0] = 12'h5A5;
        burst(next_start(t + 1), 0, 2, pr);
        chk("restart_after_timeout", data_out, 32'h5A5);
        chk("timeout_sticky", timeout_err, 1'b1);
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        chk("err_clear", timeout_err, 1'b0);

        // Timeout coincident with err_clear: set wins
        disable_acq();
        enable_on();
        wait_start(next_start(1));
        err_clear = 1'b1;
        for (int k = 1; k <= TMO + 1; k++) step();
        chk("set_wins_over_clear", timeout_err, 1'b1);
        step();
        chk("clear_after_set", timeout_err, 1'b0);
        err_clear = 1'b0;

        // Enable dropped during 2nd conversion of a 4-sample burst
        disable_acq();
        configure(4, 2);
        old = data_out;
        enable_on();
        wait_start(next_start(1));
        adc_done = 1'b0;
        step();
        step();
        adc_done = 1'b1;
        adc_data = 12'h100;
        step();
        adc_done = 1'b0;
        chk("second_start", adc_start, 1'b1);
        step();
        enable   = 1'b0;
        adc_done = 1'b1;
        step();
        chk("abort_busy", busy, 1'b0);
        chk("abort_no_start", adc_start, 1'b0);
        chk("abort_no_valid", data_valid, 1'b0);
        chk("abort_data_held", data_out, old);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("disabled_no_valid", data_valid, 1'b0);
        end
        adc_done = 1'b0;
        smp[0] = 12'd40; smp[1] = 12'd44; smp[2] = 12'd48; smp[3] = 12'd52;
        enable_on();
        burst(next_start(1), 2, 1, pr);
        chk("fresh_burst", data_out, 32'd46);

        // Period 0 with adc_done held high: back-to-back bursts
        disable_acq();
        configure(0, 1);
        hold_done = 1'b1;
        adc_done  = 1'b1;
        smp[0] = 12'd100; smp[1] = 12'd301;
        enable_on();
        burst(next_start(1), 1, 1, pr);
        burst(next_start(pr + 2), 1, 1, pr);
        smp[0] = 12'd5; smp[1] = 12'd6;
        burst(next_start(pr + 2), 1, 1, pr);
        chk("held_done_avg", data_out, 32'd5);
        hold_done = 1'b0;
        adc_done  = 1'b0;

        // Asynchronous reset mid-burst
        disable_acq();
        configure(2, 3);
        enable_on();
        wait_start(next_start(1));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_start", adc_start, 1'b0);
        chk("async_reset_busy", busy, 1'b0);
        chk("async_reset_data_out", data_out, 32'd0);
        chk("async_reset_valid", data_valid, 1'b0);
        chk("async_reset_err", timeout_err, 1'b0);
        step();
        enable = 1'b0;
        step();
        reset = 1'b0;

        // Random bursts against the reference model
        rnd_cfg = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            disable_acq();
            configure(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
            enable_on();
            pr = 0;
            for (int b = 0; b < 4; b++) begin
                int lg;
                int dly;
                lg    = clamp_lg(int'(avg_log2));
                dly   = int'($urandom_range(1, 4));
                stray = 1'($urandom_range(0, 1));
                for (int k = 0; k < 8; k++) smp[k] = 12'($urandom);
                burst((b == 0) ? next_start(1) : next_start(pr + 2), lg, dly, pr);
            end
        end
        rnd_cfg = 1'b0;
        stray   = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
